// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the fetch front end and the decoder.
// Revision: 1.0
`default_nettype none

package cpu_pkg;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_entry_t;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] INSTR_NOP        = 16'hF000;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush, occupancy count and full/empty flags.
// Revision: 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps pointers correct for non power-of-two depths.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && full_o && !pop_i));

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// instr_fetch: issues instruction-word reads, buffers returns with their PC and
// hands them to decode; a redirect flushes the buffer and discards in-flight reads.
`default_nettype none

module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = FCW + OW + 1;

  logic [15:0]    fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]  discard_q, discard_d;
  logic [OW-1:0]  outstanding;
  logic [15:0]    trk_pc;
  logic           trk_full, trk_empty;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full, fifo_empty;
  logic [CRW-1:0] credit_used;
  logic           gnt, rvalid_ok, drop_word, fifo_push, fifo_pop;
  fetch_entry_t   fifo_wdata, fifo_head;

  // Buffered words plus reads that will still land in the buffer must fit.
  assign credit_used = CRW'(fifo_count) + CRW'(outstanding) - CRW'(discard_q);

  assign mem_req   = rst_n && !redirect_valid && !trk_full &&
                     (credit_used < CRW'(FIFO_DEPTH));
  assign mem_addr  = fetch_pc_q;
  assign gnt       = mem_req && mem_gnt;
  assign rvalid_ok = mem_rvalid && !trk_empty;
  assign drop_word = (discard_q != '0);
  assign fifo_push = rvalid_ok && !drop_word && !redirect_valid;
  assign fifo_pop  = instr_valid && instr_ready && !redirect_valid;

  assign fifo_wdata  = '{instr: mem_rdata, pc: trk_pc};
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;

  // The tracker is never flushed: discarded returns still pop their own entry,
  // so its occupancy is exactly the number of reads in flight.
  sync_fifo #(
    .WIDTH (16),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (gnt),
    .wdata_i (fetch_pc_q),
    .pop_i   (rvalid_ok),
    .rdata_o (trk_pc),
    .count_o (outstanding),
    .full_o  (trk_full),
    .empty_o (trk_empty)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      discard_d  = outstanding - OW'(rvalid_ok);
      fetch_pc_d = redirect_pc & 16'hFFFE;
    end else begin
      if (rvalid_ok && drop_word) begin
        discard_d = discard_q - 1'b1;
      end
      if (gnt) begin
        fetch_pc_d = fetch_pc_q + 16'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC & 16'hFFFE;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid |-> !trk_empty);

  a_full_credit: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full |-> (outstanding == discard_q));

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with an in-order fixed-latency memory model.
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  instr_fetch #(
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] got_q[$];
  int          cyc, lat, n_grants, first_grant, first_valid, max_out;
  int          n_checks, n_errors;
  logic        obs_req, obs_valid;
  logic [15:0] obs_addr;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word_of(resp_q[0].addr);
    end
    #1;
    obs_req   = mem_req;
    obs_addr  = mem_addr;
    obs_valid = instr_valid;
    if (mem_req && mem_gnt) begin
      resp_q.push_back('{addr: mem_addr, due: cyc + lat});
      n_grants++;
      if (first_grant < 0) first_grant = cyc;
    end
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (instr_valid && instr_ready && !redirect_valid) got_q.push_back({instr_pc, instr});
    @(posedge clk);
    if (mem_rvalid) resp_q.delete(0);
    if (resp_q.size() > max_out) max_out = resp_q.size();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 16'h0000;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    resp_q.delete();
    got_q.delete();
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    cyc         = 0;
    n_grants    = 0;
    first_grant = -1;
    first_valid = -1;
    max_out     = 0;
  endtask

  task automatic check_got(input string tag, input int idx, input logic [15:0] pc);
    if (idx < got_q.size()) check(tag, got_q[idx], {pc, word_of(pc)});
    else check(tag, 32'hDEAD_DEAD, {pc, word_of(pc)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    lat      = 1;

    // Outputs held inactive while reset is asserted.
    rst_n = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 16'h0;
    instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);

    // Streaming, single-cycle memory.
    do_reset();
    lat = 1; mem_gnt = 1'b1; instr_ready = 1'b1;
    repeat (12) tick();
    check("stream_first_latency", 32'(first_valid - first_grant), 32'd2);
    for (int i = 0; i < 6; i++) check_got("stream_entry", i, 16'(2 * i));

    // Decode stalled: credit stops issue at FIFO depth.
    do_reset();
    lat = 1; mem_gnt = 1'b1; instr_ready = 1'b0;
    repeat (10) tick();
    check("stall_grants", 32'(n_grants), 32'd4);
    check("stall_req_low", 32'(obs_req), 32'd0);
    instr_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) check_got("stall_drain", i, 16'(2 * i));

    // Three-cycle memory: outstanding limit.
    do_reset();
    lat = 3; mem_gnt = 1'b1; instr_ready = 1'b1;
    repeat (3) tick();
    check("lat3_req_drop", 32'(obs_req), 32'd0);
    repeat (20) tick();
    check("lat3_max_outstanding", 32'(max_out), 32'd2);
    for (int i = 0; i < 6; i++) check_got("lat3_entry", i, 16'(2 * i));

    // Redirect with two reads in flight and one word buffered.
    do_reset();
    lat = 3; instr_ready = 1'b0;
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; repeat (2) tick();
    mem_gnt = 1'b1; repeat (2) tick();
    check("redir_grants", 32'(n_grants), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 16'h0123; instr_ready = 1'b1;
    got_q.delete();
    tick();
    check("redir_req_blocked", 32'(obs_req), 32'd0);
    check("redir_valid_before", 32'(obs_valid), 32'd1);
    redirect_valid = 1'b0;
    tick();
    check("redir_valid_after", 32'(obs_valid), 32'd0);
    check("redir_req_while_discarding", 32'(obs_req), 32'd0);
    tick();
    check("redir_req_restart", 32'(obs_req), 32'd1);
    check("redir_addr_restart", 32'(obs_addr), 32'h0122);
    repeat (6) tick();
    check_got("redir_first_delivered", 0, 16'h0122);

    // Address wrap, with bit 0 of the redirect target ignored.
    do_reset();
    lat = 1; mem_gnt = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFD;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    check_got("wrap_0", 0, 16'hFFFC);
    check_got("wrap_1", 1, 16'hFFFE);
    check_got("wrap_2", 2, 16'h0000);

    // Redirect coinciding with a returning word and decode ready, FIFO nearly full.
    do_reset();
    lat = 2; mem_gnt = 1'b1; instr_ready = 1'b0;
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0400; instr_ready = 1'b1;
    got_q.delete();
    tick();
    check("coinc_req_blocked", 32'(obs_req), 32'd0);
    check("coinc_valid_before", 32'(obs_valid), 32'd1);
    redirect_valid = 1'b0;
    tick();
    check("coinc_valid_after", 32'(obs_valid), 32'd0);
    check("coinc_req_restart", 32'(obs_req), 32'd1);
    check("coinc_addr_restart", 32'(obs_addr), 32'h0400);
    repeat (6) tick();
    check_got("coinc_first_delivered", 0, 16'h0400);
    check_got("coinc_second_delivered", 1, 16'h0402);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Producer side of the decoder's 16-bit `instr` input.
- Issues word reads to instruction memory and buffers returned words with their PC in a small FIFO.
- Presents instructions to the decode stage with a valid/ready handshake.
- On a branch/jump redirect from execute, flushes buffered and in-flight fetches and restarts at the new PC.

Parameters:
- FIFO_DEPTH, 4, number of buffered instruction entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum memory reads granted but not yet returned (>=1).
- RESET_PC, 16'h0000, first fetch address after reset (bit 0 must be 0).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mem_req  out  1  read request valid.
- mem_addr  out  16  byte address of requested word, bit 0 always 0.
- mem_gnt  in  1  request accepted this cycle (transfer on mem_req & mem_gnt).
- mem_rvalid  in  1  read data valid; responses return in request order, latency >=1 cycle after grant.
- mem_rdata  in  16  returned instruction word.
- instr_valid  out  1  instr/instr_pc valid toward decoder.
- instr  out  16  instruction word.
- instr_pc  out  16  byte address of instr (used by addpc/branch).
- instr_ready  in  1  decode accepts (transfer on instr_valid & instr_ready).
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  16  new fetch address; bit 0 is ignored and forced to 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: fetch_pc=RESET_PC, fifo empty, outstanding=0, discard=0.
  - Outputs during and after reset: mem_req=0, instr_valid=0, instr=0, instr_pc=0.
- Issue (combinational):
  - mem_req = !redirect_valid & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding - discard < FIFO_DEPTH).
  - mem_addr = fetch_pc.
  - Memory samples only on req&gnt; withdrawing req without gnt is legal.
- On req&gnt: fetch_pc += 2 (16-bit wrap, FFFE -> 0000); outstanding += 1. Each request also queues its PC in an in-order PC tracker of depth MAX_OUTSTANDING.
- On mem_rvalid:
  - outstanding -= 1.
  - If discard>0: discard -= 1 and the word is dropped.
  - Else: push {mem_rdata, tracked pc} into the FIFO.
  - The credit rule guarantees no overflow. A push into a full FIFO is an assertion failure.
- Output:
  - instr_valid = fifo not empty; instr/instr_pc = FIFO head. These are registered outputs, not combinational from mem_rdata.
  - Minimum latency is gnt -> rvalid (>=1) plus 1 cycle to instr_valid.
  - Head holds stable while valid & !ready.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Redirect (highest priority, takes effect at the clock edge where redirect_valid=1):
  - FIFO cleared; instr_valid=0 next cycle, and any instr_ready that cycle is ignored.
  - discard <= outstanding minus 1 if a non-discarded rvalid arrives the same cycle (that word is also dropped). If the arriving word was already a discard, decrement accordingly.
  - fetch_pc <= {redirect_pc[15:1],1'b0}; PC tracker entries become don't-care; no request is issued that cycle.
  - Back-to-back redirects: the last one wins; discard accounting stays exact.
- mem_rvalid with outstanding=0 is a protocol error: assertion, ignored.
- Async reset mid-operation: all state returns to reset values immediately. In-flight responses after reset are a system-level violation and not handled.

Decomposition:
- Shared package cpu_pkg:
  - fetch_entry_t (packed {logic [15:0] instr; logic [15:0] pc;}).
  - RESET_PC default constant.
  - INSTR_NOP = 16'hF000.
- Sub-module sync_fifo:
  - Parameterized width/depth, with flush input, count output, and full/empty.
  - Instantiated for the instruction FIFO (width = $bits(fetch_entry_t)) and the PC tracker.
- instr_fetch holds the issue logic, discard counter and redirect handling.

Test Plan:
- Reset release, mem_gnt=1, 1-cycle rvalid returning addr-derived words, instr_ready=1 -> instr_pc sequence 0000,0002,0004... contiguous; first instr_valid 2 cycles after first grant.
- instr_ready=0, memory always ready -> exactly FIFO_DEPTH=4 requests issued, then mem_req=0; on ready=1, entries 0000..0006 drained in order with no loss.
- 3-cycle memory latency, MAX_OUTSTANDING=2 -> never more than 2 grants outstanding; mem_req drops after the second grant until rvalid.
- Redirect to 16'h0123 with 2 outstanding and 1 buffered -> instr_valid=0 next cycle; 2 subsequent responses discarded; next mem_addr=0122 and next delivered instr_pc=0122.
- fetch_pc=FFFC -> instr_pc sequence FFFC,FFFE,0000.
- Redirect in the same cycle as rvalid and instr_ready with a full FIFO -> returned word dropped, no pop observed, discard equals outstanding-1, no overflow assertion.
